// File: rtl/hasti_sram.sv
// AHB-Lite (HASTI) SRAM slave: word-organised memory with byte/half/word
// access, programmable wait states and a two-cycle ERROR response.
`timescale 1ns/1ps
module hasti_sram #(
   parameter int DEPTH       = 256,
   parameter int WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        hreset,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic        hwrite,
   input  logic [2:0]  hsize,
   input  logic [2:0]  hburst,
   input  logic [3:0]  hprot,
   input  logic [1:0]  htrans,
   input  logic        hmastlock,
   input  logic [31:0] hwdata,
   input  logic        hready,
   output logic        hreadyout,
   output logic [31:0] hrdata,
   output logic        hresp
);

   localparam int          AW    = $clog2(DEPTH);
   localparam logic [31:0] BASE  = 32'h2000_0000;
   localparam logic [31:0] BYTES = 32'(DEPTH * 4);
   localparam logic [3:0]  WS    = 4'(WAIT_STATES);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_DATA,
      S_ERR1,
      S_ERR2
   } state_t;

   state_t        r_state;
   state_t        w_next;
   logic [3:0]    r_cnt;
   logic [3:0]    w_cnt;
   logic [AW-1:0] r_idx;
   logic [1:0]    r_off;
   logic [1:0]    r_size;
   logic          r_write;
   logic [31:0]   r_mem [DEPTH];

   logic          w_accept;
   logic          w_open;
   logic          w_illegal;
   logic          w_capture;
   logic [31:0]   w_off;
   logic [3:0]    w_be;
   logic          w_unused;

   assign w_unused = ^{hburst, hprot, hmastlock, htrans[0]};

   // Window offset is a full 32-bit subtract so addresses outside the
   // slot (above or below the base) fall out as out-of-range.
   assign w_off    = haddr - BASE;
   assign w_open   = (r_state == S_IDLE) || (r_state == S_DATA) ||
                     (r_state == S_ERR2);
   assign w_accept = hsel & hready & htrans[1];

   assign w_illegal = (hsize > 3'd2) ||
                      ((hsize == 3'd1) && haddr[0]) ||
                      ((hsize == 3'd2) && (haddr[1:0] != 2'b00)) ||
                      (w_off >= BYTES);

   assign w_capture = w_open & w_accept & ~w_illegal;

   always_comb begin
      w_next = r_state;
      w_cnt  = r_cnt;
      unique case (r_state)
         S_WAIT: begin
            w_cnt = r_cnt - 4'd1;
            if (r_cnt <= 4'd1) begin
               w_next = S_DATA;
            end
         end
         S_ERR1: begin
            w_next = S_ERR2;
         end
         S_IDLE, S_DATA, S_ERR2: begin
            w_next = S_IDLE;
            if (w_accept) begin
               if (w_illegal) begin
                  w_next = S_ERR1;
               end else if (WS == 4'd0) begin
                  w_next = S_DATA;
               end else begin
                  w_next = S_WAIT;
                  w_cnt  = WS;
               end
            end
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge hclk or posedge hreset) begin
      if (hreset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_idx   <= '0;
         r_off   <= 2'd0;
         r_size  <= 2'd0;
         r_write <= 1'b0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt;
         if (w_capture) begin
            r_idx   <= haddr[AW+1:2];
            r_off   <= haddr[1:0];
            r_size  <= hsize[1:0];
            r_write <= hwrite;
         end
      end
   end

   always_comb begin
      w_be = 4'b0000;
      unique case (r_size)
         2'd0:    w_be = 4'b0001 << r_off;
         2'd1:    w_be = r_off[1] ? 4'b1100 : 4'b0011;
         default: w_be = 4'b1111;
      endcase
   end

   // Memory has no reset; contents survive hreset.
   always_ff @(posedge hclk) begin
      if ((r_state == S_DATA) && r_write) begin
         for (int i = 0; i < 4; i++) begin
            if (w_be[i]) begin
               r_mem[r_idx][8*i +: 8] <= hwdata[8*i +: 8];
            end
         end
      end
   end

   assign hreadyout = !((r_state == S_WAIT) || (r_state == S_ERR1));
   assign hresp     = (r_state == S_ERR1) || (r_state == S_ERR2);
   assign hrdata    = ((r_state == S_DATA) && !r_write) ?
                      r_mem[r_idx] : 32'h0;

endmodule

// File: tb/tb_hasti_sram.sv
// Directed self-checking bench for hasti_sram, with one zero-wait and
// one three-wait instance sharing the bus signals.
`timescale 1ns/1ps
module tb_hasti_sram;

   logic        hclk = 1'b0;
   logic        hreset;
   logic        sel0;
   logic        sel3;
   logic [31:0] haddr;
   logic        hwrite;
   logic [2:0]  hsize;
   logic [2:0]  hburst;
   logic [3:0]  hprot;
   logic [1:0]  htrans;
   logic        hmastlock;
   logic [31:0] hwdata;
   logic        hready;
   logic        force_lo;
   logic        use3;

   logic        ro0;
   logic [31:0] rd0;
   logic        rs0;
   logic        ro3;
   logic [31:0] rd3;
   logic        rs3;

   int nchk  = 0;
   int nfail = 0;

   always #5 hclk = ~hclk;

   assign hready = force_lo ? 1'b0 : (use3 ? ro3 : ro0);

   hasti_sram #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
      .hclk(hclk), .hreset(hreset), .hsel(sel0), .haddr(haddr),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
      .hready(hready), .hreadyout(ro0), .hrdata(rd0), .hresp(rs0)
   );

   hasti_sram #(.DEPTH(256), .WAIT_STATES(3)) dut3 (
      .hclk(hclk), .hreset(hreset), .hsel(sel3), .haddr(haddr),
      .hwrite(hwrite), .hsize(hsize), .hburst(hburst), .hprot(hprot),
      .htrans(htrans), .hmastlock(hmastlock), .hwdata(hwdata),
      .hready(hready), .hreadyout(ro3), .hrdata(rd3), .hresp(rs3)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge hclk);
      #1;
   endtask

   task automatic ap(input logic [1:0] tr, input logic [31:0] a,
                     input logic w, input logic [2:0] sz);
      htrans = tr;
      haddr  = a;
      hwrite = w;
      hsize  = sz;
   endtask

   task automatic err_seq(input string tag, input logic [31:0] a,
                          input logic w, input logic [2:0] sz);
      ap(2'd2, a, w, sz);
      tick();
      hwdata = 32'hFFFF_FFFF;
      chk({tag, "_err1_rdy"}, {31'd0, ro0}, 32'd0);
      chk({tag, "_err1_resp"}, {31'd0, rs0}, 32'd1);
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      tick();
      chk({tag, "_err2_rdy"}, {31'd0, ro0}, 32'd1);
      chk({tag, "_err2_resp"}, {31'd0, rs0}, 32'd1);
      tick();
      chk({tag, "_idle_resp"}, {31'd0, rs0}, 32'd0);
   endtask

   initial begin
      hreset    = 1'b1;
      sel0      = 1'b0;
      sel3      = 1'b0;
      hburst    = 3'd0;
      hprot     = 4'd0;
      hmastlock = 1'b0;
      hwdata    = 32'h0;
      force_lo  = 1'b0;
      use3      = 1'b0;
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      repeat (2) @(posedge hclk);
      #1;
      chk("rst_rdy0", {31'd0, ro0}, 32'd1);
      chk("rst_resp0", {31'd0, rs0}, 32'd0);
      chk("rst_rdata0", rd0, 32'h0);
      chk("rst_rdy3", {31'd0, ro3}, 32'd1);
      chk("rst_resp3", {31'd0, rs3}, 32'd0);
      chk("rst_rdata3", rd3, 32'h0);
      hreset = 1'b0;

      // zero-wait word write then back-to-back read
      sel0 = 1'b1;
      ap(2'd2, 32'h2000_0010, 1'b1, 3'd2);
      tick();
      chk("w0_wr_rdy", {31'd0, ro0}, 32'd1);
      hwdata = 32'hDEAD_BEEF;
      ap(2'd2, 32'h2000_0010, 1'b0, 3'd2);
      tick();
      chk("w0_rd_rdy", {31'd0, ro0}, 32'd1);
      chk("w0_rd_resp", {31'd0, rs0}, 32'd0);
      chk("w0_rd_data", rd0, 32'hDEAD_BEEF);
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      hwdata = 32'h0;
      tick();
      chk("w0_idle_rdata", rd0, 32'h0);

      // byte and half lane merges
      ap(2'd2, 32'h2000_0020, 1'b1, 3'd2);
      tick();
      hwdata = 32'h1122_3344;
      ap(2'd2, 32'h2000_0023, 1'b1, 3'd0);
      tick();
      hwdata = 32'hAA5A_5A5A;
      ap(2'd2, 32'h2000_0020, 1'b0, 3'd2);
      tick();
      chk("byte_merge", rd0, 32'hAA22_3344);
      ap(2'd2, 32'h2000_0022, 1'b1, 3'd1);
      tick();
      hwdata = 32'h5566_7788;
      ap(2'd2, 32'h2000_0021, 0, 3'd0);
      tick();
      chk("half_merge", rd0, 32'h5566_3344);
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      tick();

      // illegal transfers
      err_seq("misalign_word", 32'h2000_0002, 1'b0, 3'd2);
      err_seq("misalign_half", 32'h2000_0021, 1'b1, 3'd1);
      err_seq("size3", 32'h2000_0020, 1'b1, 3'd3);
      err_seq("oob", 32'h2000_0400, 1'b1, 3'd2);
      err_seq("high_alias", 32'h3000_0020, 1'b1, 3'd2);
      err_seq("below_base", 32'h1FFF_FFFC, 1'b1, 3'd2);
      ap(2'd2, 32'h2000_0020, 1'b0, 3'd2);
      tick();
      chk("after_err_data", rd0, 32'h5566_3344);

      // BUSY and hready-low transfers are not accepted
      ap(2'd1, 32'h2000_0020, 1'b1, 3'd2);
      tick();
      chk("busy_rdy", {31'd0, ro0}, 32'd1);
      chk("busy_resp", {31'd0, rs0}, 32'd0);
      chk("busy_rdata", rd0, 32'h0);
      force_lo = 1'b1;
      ap(2'd2, 32'h2000_0020, 1'b1, 3'd2);
      tick();
      chk("nrdy_rdy", {31'd0, ro0}, 32'd1);
      chk("nrdy_resp", {31'd0, rs0}, 32'd0);
      force_lo = 1'b0;
      hwdata   = 32'hFFFF_FFFF;
      ap(2'd2, 32'h2000_0020, 1'b0, 3'd2);
      tick();
      chk("nrdy_data", rd0, 32'h5566_3344);
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      tick();

      // three wait states
      sel0 = 1'b0;
      sel3 = 1'b1;
      use3 = 1'b1;
      ap(2'd2, 32'h2000_0040, 1'b1, 3'd2);
      tick();
      hwdata = 32'hCAFE_F00D;
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ws_wr_wait%0d", i), {31'd0, ro3}, 32'd0);
         tick();
      end
      chk("ws_wr_data_rdy", {31'd0, ro3}, 32'd1);
      ap(2'd2, 32'h2000_0040, 1'b0, 3'd2);
      tick();
      ap(2'd2, 32'h2000_0044, 1'b1, 3'd2);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ws_rd_wait%0d", i), {31'd0, ro3}, 32'd0);
         chk($sformatf("ws_rd_wdata%0d", i), rd3, 32'h0);
         tick();
      end
      chk("ws_rd_rdy", {31'd0, ro3}, 32'd1);
      chk("ws_rd_data", rd3, 32'hCAFE_F00D);
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      tick();
      chk("ws_after_rdy", {31'd0, ro3}, 32'd1);
      chk("ws_after_rdata", rd3, 32'h0);

      // reset in the second wait cycle of a write
      ap(2'd2, 32'h2000_0040, 1'b1, 3'd2);
      tick();
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      hwdata = 32'h1234_5678;
      tick();
      chk("rstw_wait2", {31'd0, ro3}, 32'd0);
      #2;
      hreset = 1'b1;
      #1;
      chk("rstw_rdy", {31'd0, ro3}, 32'd1);
      chk("rstw_resp", {31'd0, rs3}, 32'd0);
      chk("rstw_rdata", rd3, 32'h0);
      @(posedge hclk);
      @(posedge hclk);
      #1;
      hreset = 1'b0;
      ap(2'd2, 32'h2000_0040, 1'b0, 3'd2);
      tick();
      ap(2'd0, 32'h0, 1'b0, 3'd0);
      repeat (3) tick();
      chk("rstw_keep_rdy", {31'd0, ro3}, 32'd1);
      chk("rstw_keep_data", rd3, 32'hCAFE_F00D);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures",
               nchk, nfail);
      $finish;
   end

endmodule
